booth_ctrl: RTL and testbench

Sequencing controller for the radix-2 Booth multiplier. It issues load/hold/clear/add/subtract/shift controls to the M, A and Q registers, including the load/hold control of the M register. It runs exactly WIDTH Booth iterations per operation and has a start/busy/done handshake toward the surrounding system. It contains no datapath: it decides each iteration's operation from the Q0 and Q-1 bits fed back from the datapath.

---
 rtl/booth_if.sv | 28 ++
 rtl/booth_ctrl.sv | 149 ++++++++++++++
 tb/tb_booth_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_if.sv
// booth_if: handshake and control bundle between the Booth sequencing
// controller (slave side) and the surrounding system plus datapath (master).
interface booth_if #(
    parameter int WIDTH = 4
);
    localparam int IW = $clog2(WIDTH + 1);

    logic          start;
    logic          q0;
    logic          qm1;
    logic          m_ctrl;
    logic [1:0]    q_ctrl;
    logic [1:0]    a_ctrl;
    logic          ash;
    logic          busy;
    logic          done;
    logic [IW-1:0] iter;

    modport master (
        output start, q0, qm1,
        input  m_ctrl, q_ctrl, a_ctrl, ash, busy, done, iter
    );

    modport slave (
        input  start, q0, qm1,
        output m_ctrl, q_ctrl, a_ctrl, ash, busy, done, iter
    );
endinterface

// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencing controller for a radix-2 Booth multiplier datapath.
// Issues M/Q/A register controls and runs WIDTH Booth iterations per operation.
// Optional macro BOOTH_CTRL_FAST_EN: an EVAL whose {q0,qm1} pair needs no
// add/subtract shifts in the same cycle and skips the SHIFT state.
//
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | load M and Q, clear A and Q-1
//   EVAL  | add/subtract M per the {q0,qm1} pair
//   SHIFT | arithmetic right shift of A:Q:Q-1, count one iteration
//   DONE  | one-cycle completion, may restart directly into LOAD
module booth_ctrl #(
    parameter int   WIDTH     = 4,
    parameter logic CTRL_LOAD = 1'b1,
    parameter logic CTRL_HOLD = 1'b0
) (
    input logic    clk,
    input logic    rst_n,
    booth_if.slave bus
);
    localparam int IW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EVAL  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state;
    logic [IW-1:0] iter_r;
    logic          m_r;
    logic [1:0]    q_r;
    logic [1:0]    a_r;
    logic          ash_r;
    logic          busy_r;
    logic          done_r;
    logic [1:0]    booth_op;
    logic          fast_skip;
    logic          last_iter;

    assign last_iter = (iter_r == IW'(1));

    // Booth recoding of the current {q0,qm1} pair into an A operation
    always_comb begin
        booth_op = 2'b00;
        case ({bus.q0, bus.qm1})
            2'b10:   booth_op = 2'b11;
            2'b01:   booth_op = 2'b10;
            default: booth_op = 2'b00;
        endcase
    end

`ifdef BOOTH_CTRL_FAST_EN
    assign fast_skip = (state == S_EVAL) && (bus.q0 == bus.qm1);
`else
    assign fast_skip = 1'b0;
`endif

    // State, iteration counter and registered outputs for the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            iter_r <= '0;
            m_r    <= CTRL_HOLD;
            q_r    <= 2'b00;
            a_r    <= 2'b00;
            ash_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            m_r    <= CTRL_HOLD;
            q_r    <= 2'b00;
            a_r    <= 2'b00;
            ash_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state  <= S_LOAD;
                        m_r    <= CTRL_LOAD;
                        q_r    <= 2'b01;
                        a_r    <= 2'b01;
                        busy_r <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state  <= S_EVAL;
                    iter_r <= IW'(WIDTH);
                    busy_r <= 1'b1;
                end
                S_EVAL: begin
                    if (fast_skip) begin
                        if (iter_r != '0) iter_r <= iter_r - IW'(1);
                        if (last_iter) begin
                            state  <= S_DONE;
                            done_r <= 1'b1;
                        end else begin
                            state  <= S_EVAL;
                            busy_r <= 1'b1;
                        end
                    end else begin
                        state  <= S_SHIFT;
                        ash_r  <= 1'b1;
                        q_r    <= 2'b10;
                        busy_r <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (iter_r != '0) iter_r <= iter_r - IW'(1);
                    if (last_iter) begin
                        state  <= S_DONE;
                        done_r <= 1'b1;
                    end else begin
                        state  <= S_EVAL;
                        busy_r <= 1'b1;
                    end
                end
                S_DONE: begin
                    iter_r <= '0;
                    if (bus.start) begin
                        state  <= S_LOAD;
                        m_r    <= CTRL_LOAD;
                        q_r    <= 2'b01;
                        a_r    <= 2'b01;
                        busy_r <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    iter_r <= '0;
                end
            endcase
        end
    end

    // a_ctrl follows the bit pair directly in EVAL so a late q0/qm1 still lands
    assign bus.a_ctrl = (state == S_EVAL) ? booth_op : a_r;
    assign bus.q_ctrl = fast_skip ? 2'b10 : q_r;
    assign bus.ash    = ash_r | fast_skip;
    assign bus.m_ctrl = m_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.iter   = iter_r;
endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: Booth controller bench with a behavioural datapath and a
// per-operation expected-trace model derived from the operand bits.
module tb_booth_ctrl;
    localparam int W  = 4;
    localparam int IW = $clog2(W + 1);
`ifdef BOOTH_CTRL_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct packed {
        logic          m;
        logic [1:0]    q;
        logic [1:0]    a;
        logic          ash;
        logic          busy;
        logic          done;
        logic [IW-1:0] iter;
        logic          chk;
        logic [2*W-1:0] prod;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [W-1:0] m_in = '0;
    logic [W-1:0] q_in = '0;
    int checks = 0;
    int errors = 0;

    logic [W-1:0] dp_a = '0;
    logic [W-1:0] dp_q = '0;
    logic [W-1:0] dp_m = '0;
    logic         dp_qm1 = 1'b0;

    logic       s_m = 1'b0;
    logic [1:0] s_q = 2'b00;
    logic [1:0] s_a = 2'b00;
    logic       s_ash = 1'b0;

    exp_t exp_q[$];

    booth_if #(.WIDTH(W)) bus ();

    booth_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.q0  = dp_q[0];
    assign bus.qm1 = dp_qm1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.m_ctrl, bus.q_ctrl, bus.a_ctrl, bus.ash, bus.busy, bus.done, bus.iter});
    endfunction

    function automatic logic [31:0] pack_exp(input exp_t e);
        return 32'({e.m, e.q, e.a, e.ash, e.busy, e.done, e.iter});
    endfunction

    // Expected per-cycle trace of one operation, derived from the Booth bit pairs of Q
    function automatic void build(input logic [W-1:0] m, input logic [W-1:0] q);
        exp_t e;
        int   cnt;
        logic prev;
        logic b;
        logic signed [2*W-1:0] p;
        cnt  = W;
        prev = 1'b0;
        e = '0; e.m = 1'b1; e.q = 2'b01; e.a = 2'b01; e.busy = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < W; i++) begin
            b = q[i];
            e = '0; e.busy = 1'b1; e.iter = IW'(cnt);
            if (FAST && (b == prev)) begin
                e.q = 2'b10; e.ash = 1'b1;
                exp_q.push_back(e);
            end else begin
                e.a = (b && !prev) ? 2'b11 : ((!b && prev) ? 2'b10 : 2'b00);
                exp_q.push_back(e);
                e.a = 2'b00; e.q = 2'b10; e.ash = 1'b1;
                exp_q.push_back(e);
            end
            cnt--;
            prev = b;
        end
        p = $signed(m) * $signed(q);
        e = '0; e.done = 1'b1; e.chk = 1'b1; e.prod = p;
        exp_q.push_back(e);
    endfunction

    // Compare process: every cycle, checked mid-cycle against the model
    always @(negedge clk) begin
        exp_t e;
        s_m = bus.m_ctrl; s_q = bus.q_ctrl; s_a = bus.a_ctrl; s_ash = bus.ash;
        e = '0;
        if (!rst_n) exp_q.delete();
        else if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("model_outs", outs(), pack_exp(e));
        if (e.chk) chk("model_product", 32'({dp_a, dp_q}), 32'(e.prod));
        if (rst_n && exp_q.size() == 0 && bus.start) build(m_in, q_in);
    end

    // Behavioural datapath: applies the controls sampled in the cycle just ending
    always @(posedge clk) begin
        logic [W-1:0] a_n;
        logic [W-1:0] q_n;
        logic         qm_n;
        a_n = dp_a; q_n = dp_q; qm_n = dp_qm1;
        if (rst_n) begin
            if (s_m) dp_m <= m_in;
            case (s_a)
                2'b01: begin a_n = '0; qm_n = 1'b0; end
                2'b10: a_n = dp_a + dp_m;
                2'b11: a_n = dp_a - dp_m;
                default: ;
            endcase
            if (s_q == 2'b01) q_n = q_in;
            if (s_ash) {a_n, q_n, qm_n} = {a_n[W-1], a_n, q_n};
            dp_a <= a_n; dp_q <= q_n; dp_qm1 <= qm_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((bus.busy || bus.done) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk({name, "_idle_timeout"}, 32'(n), 32'(0));
    endtask

    // One operation with hand-computed latency, EVAL a_ctrl sequence, iter sequence and product
    task automatic run_op(input string name, input logic [W-1:0] m, input logic [W-1:0] q,
                          input int exp_edge, input int exp_n, input logic [7:0] exp_seq,
                          input logic [23:0] exp_it, input logic [2*W-1:0] exp_prod);
        int got, nb, n, ni;
        logic [7:0]  seq;
        logic [23:0] its;
        got = -1; nb = 0; n = 0; ni = 0; seq = '0; its = '0;
        m_in = m; q_in = q; bus.start = 1'b1;
        for (int e = 0; e < 40 && got < 0; e++) begin
            tick();
            if (e == 0) bus.start = 1'b0;
            if (bus.done) begin
                got = e;
            end else if (bus.busy) begin
                nb++;
                if (bus.m_ctrl == 1'b0) begin
                    if (ni < 8) its[3*ni +: 3] = 3'(bus.iter);
                    ni++;
                    if (bus.ash == 1'b0) begin
                        if (n < 4) seq[2*n +: 2] = bus.a_ctrl;
                        n++;
                    end
                end
            end
        end
        chk({name, "_done_edge"}, 32'(got), 32'(exp_edge));
        chk({name, "_busy_cycles"}, 32'(nb), 32'(exp_edge));
        chk({name, "_eval_count"}, 32'(n), 32'(exp_n));
        chk({name, "_eval_actrl"}, 32'(seq), 32'(exp_seq));
        chk({name, "_iter_seq"}, 32'(its), 32'(exp_it));
        chk({name, "_product"}, 32'({dp_a, dp_q}), 32'(exp_prod));
        tick();
        chk({name, "_done_one_cycle"}, 32'(bus.done), 32'(0));
        wait_idle(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int got_edges[3];
        int nd;
        int found;
        logic ns;
        logic [W-1:0] mr;

        rst_n = 1'b0; bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.start = 1'($urandom_range(0, 1));
            m_in = W'($urandom); q_in = W'($urandom);
            #2;
            chk("reset_hold_outs", outs(), 32'(0));
        end
        bus.start = 1'b0; m_in = '0; q_in = '0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_after_reset", outs(), 32'(0));

        if (FAST) begin
            run_op("zeros", 4'd0, 4'd0, 5, 0, 8'b0, 24'o00001234, 8'd0);
            run_op("m3q6",  4'd3, 4'd6, 7, 2, 8'b00001011, 24'o00113234, 8'd18);
        end else begin
            run_op("zeros", 4'd0, 4'd0, 9, 4, 8'b0, 24'o11223344, 8'd0);
            run_op("m3q6",  4'd3, 4'd6, 9, 4, 8'b10001100, 24'o11223344, 8'd18);
        end

        // start held high: LOAD re-entered straight from DONE
        nd = 0;
        got_edges[0] = -1; got_edges[1] = -1; got_edges[2] = -1;
        m_in = '0; q_in = '0; bus.start = 1'b1;
        for (int e = 0; e < 32; e++) begin
            tick();
            if (bus.done && nd < 3) begin
                got_edges[nd] = e;
                nd++;
            end
        end
        bus.start = 1'b0;
        if (FAST) begin
            chk("held_done0", 32'(got_edges[0]), 32'(5));
            chk("held_done1", 32'(got_edges[1]), 32'(11));
            chk("held_done2", 32'(got_edges[2]), 32'(17));
        end else begin
            chk("held_done0", 32'(got_edges[0]), 32'(9));
            chk("held_done1", 32'(got_edges[1]), 32'(19));
            chk("held_done2", 32'(got_edges[2]), 32'(29));
        end
        wait_idle("held");
        tick();

        // reset between edges during the SHIFT of iteration 2
        m_in = 4'd5; q_in = 4'b0101; bus.start = 1'b1;
        found = 0;
        for (int e = 0; e < 20 && found == 0; e++) begin
            tick();
            bus.start = 1'b0;
            if (bus.ash && bus.iter == IW'(3)) found = 1;
        end
        chk("midop_shift_found", 32'(found), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", outs(), 32'(0));
        tick(); tick();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.busy || bus.done) nd++;
        end
        chk("post_reset_stays_idle", 32'(nd), 32'(0));

        // randomized traffic checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            ns = ($urandom_range(0, 3) == 0) ? 1'b1 : (bus.start && ($urandom_range(0, 3) != 0));
            if (ns && !bus.start) begin
                mr = W'($urandom);
                if (mr == {1'b1, {(W-1){1'b0}}}) mr = {1'b0, {(W-1){1'b1}}};
                m_in = mr;
                q_in = W'($urandom);
            end
            bus.start = ns;
            if ($urandom_range(0, 249) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rand_async_reset", outs(), 32'(0));
                tick();
                rst_n = 1'b1;
            end
        end
        bus.start = 1'b0;
        wait_idle("random_end");
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
